// File: rtl/hv_bundler_unit_if.sv
// Handshake bundle between an HV source and the bundler unit.
// The source offers hv_i/tie_i and may clear; the bundler returns the majority.
interface hv_bundler_unit_if #(
    parameter int HVDimension = 512,
    parameter int NumWidth    = 16
);
    logic [HVDimension-1:0] hv_i;
    logic                   hv_valid_i;
    logic                   hv_ready_o;
    logic                   clr_i;
    logic [HVDimension-1:0] tie_i;
    logic [HVDimension-1:0] hv_o;
    logic [NumWidth-1:0]    num_bundled_o;
    logic                   sat_o;

    modport master (
        output hv_i, hv_valid_i, clr_i, tie_i,
        input  hv_ready_o, hv_o, num_bundled_o, sat_o
    );

    modport slave (
        input  hv_i, hv_valid_i, clr_i, tie_i,
        output hv_ready_o, hv_o, num_bundled_o, sat_o
    );
endinterface

// File: rtl/hv_bundler_unit.sv
// Hypervector bundler: one saturating signed vote counter per dimension,
// binarized majority output, accepted-HV tally and sticky rail flag.
module hv_bundler_unit #(
    parameter int HVDimension  = 512,
    parameter int CounterWidth = 8,
    parameter int NumWidth     = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    hv_bundler_unit_if.slave bus
);
    typedef logic signed [CounterWidth-1:0] cnt_t;

    localparam cnt_t CntMax = cnt_t'({1'b0, {(CounterWidth-1){1'b1}}});
    localparam cnt_t CntMin = cnt_t'({1'b1, {(CounterWidth-1){1'b0}}});
    localparam logic [NumWidth-1:0] NumMax = '1;

    cnt_t                   cnt_q [HVDimension];
    cnt_t                   cnt_d [HVDimension];
    logic [HVDimension-1:0] rail;
    logic [NumWidth-1:0]    num_q;
    logic                   sat_q;
    logic                   accept;

    // Clear owns the cycle, so the source must hold its HV.
    assign bus.hv_ready_o    = ~bus.clr_i;
    assign accept            = bus.hv_valid_i & ~bus.clr_i;
    assign bus.num_bundled_o = num_q;
    assign bus.sat_o         = sat_q;

    always_comb begin
        rail = '0;
        for (int k = 0; k < HVDimension; k++) begin
            rail[k]  = bus.hv_i[k] ? (cnt_q[k] == CntMax)
                                   : (cnt_q[k] == CntMin);
            cnt_d[k] = cnt_q[k];
            if (!rail[k]) begin
                cnt_d[k] = bus.hv_i[k] ? cnt_q[k] + cnt_t'(1)
                                       : cnt_q[k] - cnt_t'(1);
            end
        end
    end

    // Zero counters fall back to the caller-supplied tie-break bit.
    always_comb begin
        bus.hv_o = '0;
        for (int k = 0; k < HVDimension; k++) begin
            bus.hv_o[k] = (cnt_q[k] > cnt_t'(0))
                        | ((cnt_q[k] == cnt_t'(0)) & bus.tie_i[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clr_i) begin
            for (int k = 0; k < HVDimension; k++) begin
                cnt_q[k] <= '0;
            end
            num_q <= '0;
            sat_q <= 1'b0;
        end else if (accept) begin
            for (int k = 0; k < HVDimension; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            if (num_q != NumMax) begin
                num_q <= num_q + NumWidth'(1);
            end
            if (|rail) begin
                sat_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hv_bundler_unit.sv
// Self-checking bench for hv_bundler_unit: a per-dimension vote model
// feeds an expectation queue that is drained after every clock edge.
module tb_hv_bundler_unit;
    localparam int HV = 512;
    localparam int NW = 16;

    typedef struct {
        logic [HV-1:0] hv;
        int            num;
        bit            sat;
    } exp_t;

    logic clk;
    logic rst;

    hv_bundler_unit_if #(.HVDimension(HV), .NumWidth(NW)) bus ();
    hv_bundler_unit_if #(.HVDimension(8), .NumWidth(4)) sbus ();

    hv_bundler_unit #(
        .HVDimension(HV), .CounterWidth(8), .NumWidth(NW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    hv_bundler_unit #(
        .HVDimension(8), .CounterWidth(8), .NumWidth(4)
    ) dut_small (
        .clk_i(clk), .rst_i(rst), .bus(sbus)
    );

    int   mcnt [HV];
    int   mnum;
    bit   msat;
    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic [HV-1:0] ones  = '1;
    logic [HV-1:0] zeros = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [HV-1:0] rand_hv();
        logic [HV-1:0] r;
        for (int i = 0; i < HV / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic drive(input bit r, input bit c, input bit v,
                         input logic [HV-1:0] h, input logic [HV-1:0] t);
        exp_t e;
        rst = r;
        bus.clr_i = c;
        bus.hv_valid_i = v;
        bus.hv_i = h;
        bus.tie_i = t;
        if (r || c) begin
            for (int k = 0; k < HV; k++) mcnt[k] = 0;
            mnum = 0;
            msat = 0;
        end else if (v) begin
            for (int k = 0; k < HV; k++) begin
                if (h[k]) begin
                    if (mcnt[k] == 127) msat = 1;
                    else mcnt[k]++;
                end else begin
                    if (mcnt[k] == -128) msat = 1;
                    else mcnt[k]--;
                end
            end
            if (mnum < 65535) mnum++;
        end
        for (int k = 0; k < HV; k++)
            e.hv[k] = (mcnt[k] > 0) || (mcnt[k] == 0 && t[k]);
        e.num = mnum;
        e.sat = msat;
        q.push_back(e);
    endtask

    task automatic tick(output exp_t e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: queue empty got 0 entries want 1");
            e.hv = '0; e.num = 0; e.sat = 0;
        end else begin
            e = q.pop_front();
        end
    endtask

    task automatic test_reset();
        exp_t e;
        logic [HV-1:0] t;
        for (int i = 0; i < 2; i++) begin
            t = rand_hv();
            drive(1, 0, 1, ones, t);
            tick(e);
            n_checks += 4;
            if (bus.hv_o !== t) begin
                n_fail++; $display("FAIL reset_hv: got %h want %h", bus.hv_o, t);
            end
            if (bus.num_bundled_o !== 16'd0) begin
                n_fail++; $display("FAIL reset_num: got %0d want 0", bus.num_bundled_o);
            end
            if (bus.sat_o !== 1'b0) begin
                n_fail++; $display("FAIL reset_sat: got %b want 0", bus.sat_o);
            end
            if (bus.hv_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL reset_ready: got %b want 1", bus.hv_ready_o);
            end
        end
    endtask

    task automatic test_single();
        exp_t e;
        logic [HV-1:0] a5 = {64{8'hA5}};
        drive(0, 0, 1, a5, zeros);
        tick(e);
        drive(0, 0, 0, zeros, zeros);
        n_checks += 2;
        if (bus.hv_o !== a5) begin
            n_fail++; $display("FAIL single_hv: got %h want %h", bus.hv_o, a5);
        end
        if (bus.num_bundled_o !== 16'd1) begin
            n_fail++; $display("FAIL single_num: got %0d want 1", bus.num_bundled_o);
        end
        tick(e);
        n_checks++;
        if (bus.hv_o !== e.hv) begin
            n_fail++; $display("FAIL single_hold: got %h want %h", bus.hv_o, e.hv);
        end
    endtask

    task automatic test_majority();
        exp_t e;
        logic [HV-1:0] t = rand_hv();
        logic [HV-1:0] seq [4];
        seq[0] = ones; seq[1] = ones; seq[2] = zeros; seq[3] = zeros;
        drive(0, 1, 0, zeros, t);
        tick(e);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, seq[i], t);
            tick(e);
            n_checks += 2;
            if (bus.hv_o !== e.hv) begin
                n_fail++; $display("FAIL majority_hv%0d: got %h want %h", i, bus.hv_o, e.hv);
            end
            if (bus.num_bundled_o !== 16'(i + 1)) begin
                n_fail++; $display("FAIL majority_num%0d: got %0d want %0d", i, bus.num_bundled_o, i + 1);
            end
        end
        n_checks++;
        if (bus.hv_o !== t) begin
            n_fail++; $display("FAIL majority_tie: got %h want %h", bus.hv_o, t);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [HV-1:0] t = rand_hv();
        drive(0, 1, 0, zeros, zeros);
        tick(e);
        for (int i = 1; i <= 130; i++) begin
            drive(0, 0, 1, ones, zeros);
            tick(e);
            n_checks += 2;
            if (bus.sat_o !== (i >= 128)) begin
                n_fail++; $display("FAIL sat_up%0d: got %b want %b", i, bus.sat_o, i >= 128);
            end
            if (bus.hv_o !== ones) begin
                n_fail++; $display("FAIL sat_up_hv%0d: got %h want all-1", i, bus.hv_o);
            end
        end
        n_checks++;
        if (bus.num_bundled_o !== 16'd130) begin
            n_fail++; $display("FAIL sat_num: got %0d want 130", bus.num_bundled_o);
        end
        // 127 -> 126 after one down vote; 126 more bring it to exactly 0.
        for (int i = 1; i <= 127; i++) begin
            drive(0, 0, 1, zeros, t);
            tick(e);
            n_checks += 2;
            if (bus.hv_o !== ((i < 127) ? ones : t)) begin
                n_fail++; $display("FAIL sat_down_hv%0d: got %h want %h", i, bus.hv_o, (i < 127) ? ones : t);
            end
            if (bus.sat_o !== 1'b1) begin
                n_fail++; $display("FAIL sat_sticky%0d: got %b want 1", i, bus.sat_o);
            end
        end
        drive(0, 1, 0, zeros, t);
        tick(e);
        for (int i = 1; i <= 129; i++) begin
            drive(0, 0, 1, zeros, t);
            tick(e);
            n_checks += 2;
            if (bus.sat_o !== (i >= 129)) begin
                n_fail++; $display("FAIL sat_dn%0d: got %b want %b", i, bus.sat_o, i >= 129);
            end
            if (bus.hv_o !== zeros) begin
                n_fail++; $display("FAIL sat_dn_hv%0d: got %h want all-0", i, bus.hv_o);
            end
        end
    endtask

    task automatic test_clear_collision();
        exp_t e;
        logic [HV-1:0] t = rand_hv();
        drive(0, 1, 1, ones, t);
        #1;
        n_checks++;
        if (bus.hv_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL clr_ready: got %b want 0", bus.hv_ready_o);
        end
        tick(e);
        n_checks += 3;
        if (bus.num_bundled_o !== 16'd0) begin
            n_fail++; $display("FAIL clr_num: got %0d want 0", bus.num_bundled_o);
        end
        if (bus.hv_o !== t) begin
            n_fail++; $display("FAIL clr_hv: got %h want %h", bus.hv_o, t);
        end
        if (bus.sat_o !== 1'b0) begin
            n_fail++; $display("FAIL clr_sat: got %b want 0", bus.sat_o);
        end
        drive(0, 0, 1, ones, t);
        tick(e);
        n_checks += 2;
        if (bus.num_bundled_o !== 16'd1) begin
            n_fail++; $display("FAIL clr_hold_num: got %0d want 1", bus.num_bundled_o);
        end
        if (bus.hv_o !== ones) begin
            n_fail++; $display("FAIL clr_hold_hv: got %h want all-1", bus.hv_o);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int acc = 0;
        int cyc = 0;
        bit v, c;
        logic [HV-1:0] t = rand_hv();
        while (acc < 1000 && cyc < 5000) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) t = rand_hv();
            drive(0, c, v, rand_hv(), t);
            tick(e);
            if (v && !c) acc++;
            cyc++;
            n_checks += 4;
            if (bus.hv_o !== e.hv) begin
                n_fail++; $display("FAIL rand_hv c%0d: got %h want %h", cyc, bus.hv_o, e.hv);
            end
            if (bus.num_bundled_o !== 16'(e.num)) begin
                n_fail++; $display("FAIL rand_num c%0d: got %0d want %0d", cyc, bus.num_bundled_o, e.num);
            end
            if (bus.sat_o !== e.sat) begin
                n_fail++; $display("FAIL rand_sat c%0d: got %b want %b", cyc, bus.sat_o, e.sat);
            end
            if (bus.hv_ready_o !== !c) begin
                n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", cyc, bus.hv_ready_o, !c);
            end
        end
        n_checks++;
        if (acc < 1000) begin
            n_fail++; $display("FAIL rand_budget: got %0d accepts want 1000", acc);
        end
    endtask

    task automatic test_tally_sat();
        exp_t e;
        sbus.hv_i = 8'hFF;
        sbus.hv_valid_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            drive(0, 0, 0, zeros, zeros);
            tick(e);
            n_checks += 3;
            if (sbus.num_bundled_o !== 4'((i < 15) ? i : 15)) begin
                n_fail++; $display("FAIL tally_sat%0d: got %0d want %0d", i, sbus.num_bundled_o, (i < 15) ? i : 15);
            end
            if (sbus.hv_o !== 8'hFF) begin
                n_fail++; $display("FAIL tally_hv%0d: got %h want ff", i, sbus.hv_o);
            end
            if (sbus.sat_o !== 1'b0) begin
                n_fail++; $display("FAIL tally_flag%0d: got %b want 0", i, sbus.sat_o);
            end
        end
        sbus.hv_valid_i = 1'b0;
    endtask

    initial begin
        sbus.hv_i = '0;
        sbus.hv_valid_i = 1'b0;
        sbus.clr_i = 1'b0;
        sbus.tie_i = '0;
        test_reset();
        test_single();
        test_majority();
        test_saturation();
        test_clear_collision();
        test_random();
        test_tally_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
